// File: rtl/perf_counter_unit_pkg.sv
// Shared types and constants for the performance-counter block and the cpu decode.
// Counter indices, map addresses and the saturating increment live here.
package perf_counter_unit_pkg;

   typedef logic [3:0] lc3b_opcode;
   typedef logic [3:0] lc3b_perf_idx;

   localparam lc3b_opcode  OP_BR        = 4'b0000;
   localparam lc3b_opcode  OP_ADD       = 4'b0001;

   localparam logic [15:0] PERF_BASE    = 16'hFFE0;
   localparam logic [15:0] PERF_CTRL    = 16'hFFFE;
   localparam int          PERF_NUM_CNT = 10;

   typedef enum lc3b_perf_idx {
      CTR_CYCLES   = 4'd0,
      CTR_RETIRED  = 4'd1,
      CTR_BRANCHES = 4'd2,
      CTR_TAKEN    = 4'd3,
      CTR_I_HIT    = 4'd4,
      CTR_I_MISS   = 4'd5,
      CTR_I_STALL  = 4'd6,
      CTR_D_HIT    = 4'd7,
      CTR_D_MISS   = 4'd8,
      CTR_D_STALL  = 4'd9
   } perf_ctr_e;

   typedef enum logic {
      EV_IDLE = 1'b0,
      EV_WAIT = 1'b1
   } ev_state_e;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/perf_counter_unit_if.sv
// Load/store path between the cpu MEM stage and the counter register space.
interface perf_counter_unit_if;
   logic [15:0] address;
   logic        counter_read;
   logic        counter_write;
   logic [15:0] wdata;
   logic [15:0] counter_data;

   modport master (
      output address, counter_read, counter_write, wdata,
      input  counter_data
   );

   modport slave (
      input  address, counter_read, counter_write, wdata,
      output counter_data
   );
endinterface

// File: rtl/perf_counter_unit_cache_event_fsm.sv
// Classifies one cache port's requests into hit (answered immediately) or miss
// (answered after waiting); requests dropped while waiting produce nothing.
module cache_event_fsm
   import perf_counter_unit_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req,
   input  logic resp,
   output logic hit,
   output logic miss
);

   ev_state_e state_reg, state_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= EV_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      hit        = 1'b0;
      miss       = 1'b0;
      unique case (state_reg)
         EV_IDLE: begin
            if (req && resp)  hit        = 1'b1;
            else if (req)     state_next = EV_WAIT;
         end
         EV_WAIT: begin
            // A response wins over a request that drops in the same cycle.
            if (resp) begin
               miss       = 1'b1;
               state_next = EV_IDLE;
            end else if (!req) begin
               state_next = EV_IDLE;
            end
         end
         default: state_next = EV_IDLE;
      endcase
   end

endmodule

// File: rtl/perf_counter_unit.sv
// Memory-mapped saturating event counters beside the MEM stage, plus an
// enable/clear control register; reads return the pre-update value.
module perf_counter_unit
   import perf_counter_unit_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = PERF_BASE,
   parameter logic [15:0] CTRL_ADDR = PERF_CTRL,
   parameter int          NUM_CNT   = PERF_NUM_CNT
)(
   input  logic                 clk,
   input  logic                 rst,
   perf_counter_unit_if.slave   bus,
   input  lc3b_opcode           mem_opcode,
   input  logic                 is_nop,
   input  logic                 pipe_advance,
   input  logic                 branch_enable,
   input  logic                 icache_read,
   input  logic                 resp_a,
   input  logic                 dcache_read,
   input  logic                 dcache_write,
   input  logic                 resp_b
);

   logic               en_reg;
   logic [NUM_CNT-1:0] ev;
   logic [15:0]        cnt_val [NUM_CNT];
   logic [14:0]        word_off;
   logic               sel_cnt, sel_ctrl;
   logic               wr_cnt, clr_wr;
   logic               i_hit, i_miss, d_hit, d_miss;
   logic [15:0]        rd_data;
   logic               unused_addr_lsb;

   assign unused_addr_lsb = bus.address[0];

   // Byte address bit 0 is dropped; an address below the base wraps to a
   // large offset and falls out of range.
   assign word_off = bus.address[15:1] - BASE_ADDR[15:1];
   assign sel_cnt  = (word_off < 15'(NUM_CNT));
   assign sel_ctrl = (bus.address[15:1] == CTRL_ADDR[15:1]);
   assign wr_cnt   = bus.counter_write && sel_cnt;
   assign clr_wr   = bus.counter_write && sel_ctrl && bus.wdata[1];

   cache_event_fsm u_i_fsm (
      .clk  (clk),
      .rst  (rst),
      .req  (icache_read),
      .resp (resp_a),
      .hit  (i_hit),
      .miss (i_miss)
   );

   cache_event_fsm u_d_fsm (
      .clk  (clk),
      .rst  (rst),
      .req  (dcache_read | dcache_write),
      .resp (resp_b),
      .hit  (d_hit),
      .miss (d_miss)
   );

   always_comb begin
      ev               = '0;
      ev[CTR_CYCLES]   = 1'b1;
      ev[CTR_RETIRED]  = pipe_advance && !is_nop;
      ev[CTR_BRANCHES] = pipe_advance && !is_nop && (mem_opcode == OP_BR);
      ev[CTR_TAKEN]    = pipe_advance && !is_nop && (mem_opcode == OP_BR) && branch_enable;
      ev[CTR_I_HIT]    = i_hit;
      ev[CTR_I_MISS]   = i_miss;
      ev[CTR_I_STALL]  = icache_read && !resp_a;
      ev[CTR_D_HIT]    = d_hit;
      ev[CTR_D_MISS]   = d_miss;
      ev[CTR_D_STALL]  = (dcache_read || dcache_write) && !resp_b;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                   en_reg <= 1'b1;
      else if (bus.counter_write && sel_ctrl)    en_reg <= bus.wdata[0];
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CNT; gi++) begin : gen_cnt
         logic [15:0] cnt_reg, cnt_next;
         logic        wr_hit;

         assign wr_hit = wr_cnt && (word_off == 15'(gi));

         // Clear beats a load, and a load beats this counter's own increment.
         always_comb begin
            cnt_next = cnt_reg;
            if (clr_wr)                  cnt_next = '0;
            else if (wr_hit)             cnt_next = bus.wdata;
            else if (en_reg && ev[gi])   cnt_next = sat_inc(cnt_reg);
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) cnt_reg <= '0;
            else     cnt_reg <= cnt_next;
         end

         assign cnt_val[gi] = cnt_reg;
      end
   endgenerate

   always_comb begin
      rd_data = '0;
      if (bus.counter_read) begin
         if (sel_ctrl) rd_data = {15'd0, en_reg};
         for (int i = 0; i < NUM_CNT; i++) begin
            if (sel_cnt && (word_off == 15'(i))) rd_data = cnt_val[i];
         end
      end
   end

   // Held at zero during reset regardless of address, even though en resets to 1.
   assign bus.counter_data = rst ? 16'h0000 : rd_data;

endmodule
